// File: rtl/ipml_prefetch_frame_reader_pkg.sv
// Shared types for the prefetch FIFO frame reader: controller state encoding.
package ipml_prefetch_frame_reader_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/ipml_frame_reader_obuf.sv
// Two-entry registered output buffer of {eop, sop, data}; entry 0 is always the head.
module ipml_frame_reader_obuf #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  sop_i,
   input  logic                  eop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  sop_o,
   output logic                  eop_o,
   output logic                  vld_o,
   output logic [1:0]            cnt_o
);

   localparam int ENTRY_W = DATA_WIDTH + 2;

   logic [ENTRY_W-1:0] entry0_q, entry0_d;
   logic [ENTRY_W-1:0] entry1_q, entry1_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [ENTRY_W-1:0] entryIn;

   assign entryIn = {eop_i, sop_i, data_i};

   // A simultaneous push and pop keeps the occupancy and shifts entry 1 forward.
   always_comb begin
      entry0_d = entry0_q;
      entry1_d = entry1_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         cnt_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (cnt_q == 2'd0) entry0_d = entryIn;
               else               entry1_d = entryIn;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               entry0_d = entry1_q;
               cnt_d    = cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  entry0_d = entryIn;
               end else begin
                  entry0_d = entry1_q;
                  entry1_d = entryIn;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         entry0_q <= '0;
         entry1_q <= '0;
         cnt_q    <= 2'd0;
      end else begin
         entry0_q <= entry0_d;
         entry1_q <= entry1_d;
         cnt_q    <= cnt_d;
      end
   end

   assign vld_o  = (cnt_q != 2'd0);
   assign cnt_o  = cnt_q;
   assign data_o = entry0_q[DATA_WIDTH-1:0];
   assign sop_o  = vld_o & entry0_q[DATA_WIDTH];
   assign eop_o  = vld_o & entry0_q[DATA_WIDTH+1];

endmodule

// File: rtl/ipml_prefetch_frame_reader.sv
// Drains one frame of frame_len words from a show-ahead FIFO per start and re-emits it as a
// sop/eop framed stream; the output buffer decouples dout_rdy from fifo_rd_en.
module ipml_prefetch_frame_reader
   import ipml_prefetch_frame_reader_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int LEN_WIDTH       = 16,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [LEN_WIDTH-1:0]       frame_len,
   input  logic                       abort,
   output logic                       busy,
   output logic                       done,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
   input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
   input  logic                       fifo_rd_vld,
   output logic                       fifo_rd_en,
   output logic [DATA_WIDTH-1:0]      dout,
   output logic                       dout_vld,
   output logic                       dout_sop,
   output logic                       dout_eop,
   input  logic                       dout_rdy
);

   state_e                     state_q, state_d;
   logic [LEN_WIDTH-1:0]       issueLeft_q, issueLeft_d;
   logic [LEN_WIDTH-1:0]       outLeft_q, outLeft_d;
   logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
   logic                       done_q, done_d;
   logic                       first_q, first_d;

   logic       rdEn;
   logic       stallCond;
   logic       outXfer;
   logic       bufFlush;
   logic [1:0] bufCnt;
   logic       bufFull;

   assign bufFull = bufCnt[1];

   // Abort gates the read enable combinationally so no word is popped in the abort cycle.
   assign rdEn = (state_q == RUN) & (issueLeft_q != '0) & ~bufFull & fifo_rd_vld & ~abort & ~rst;
   assign stallCond = (state_q == RUN) & (issueLeft_q != '0) & ~bufFull & ~fifo_rd_vld;
   assign outXfer   = dout_vld & dout_rdy;

   always_comb begin
      state_d     = state_q;
      issueLeft_d = issueLeft_q;
      outLeft_d   = outLeft_q;
      stall_d     = stall_q;
      done_d      = 1'b0;
      first_d     = first_q;
      bufFlush    = 1'b0;

      if (stallCond && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               stall_d = '0;
               if (frame_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = RUN;
                  issueLeft_d = frame_len;
                  outLeft_d   = frame_len;
                  first_d     = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d     = IDLE;
               issueLeft_d = '0;
               outLeft_d   = '0;
               bufFlush    = 1'b1;
            end else begin
               if (rdEn) begin
                  issueLeft_d = issueLeft_q - 1'b1;
                  first_d     = 1'b0;
                  if (issueLeft_q == LEN_WIDTH'(1)) state_d = FLUSH;
               end
               if (outXfer && (outLeft_q != '0)) outLeft_d = outLeft_q - 1'b1;
            end
         end
         FLUSH: begin
            if (abort) begin
               state_d     = IDLE;
               issueLeft_d = '0;
               outLeft_d   = '0;
               bufFlush    = 1'b1;
            end else if (outXfer && (outLeft_q != '0)) begin
               outLeft_d = outLeft_q - 1'b1;
               if (outLeft_q == LEN_WIDTH'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         issueLeft_q <= '0;
         outLeft_q   <= '0;
         stall_q     <= '0;
         done_q      <= 1'b0;
         first_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         issueLeft_q <= issueLeft_d;
         outLeft_q   <= outLeft_d;
         stall_q     <= stall_d;
         done_q      <= done_d;
         first_q     <= first_d;
      end
   end

   ipml_frame_reader_obuf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) uObuf (
      .clk    (clk),
      .rst    (rst),
      .push_i (rdEn),
      .pop_i  (outXfer),
      .flush_i(bufFlush),
      .data_i (fifo_rd_data),
      .sop_i  (first_q),
      .eop_i  (issueLeft_q == LEN_WIDTH'(1)),
      .data_o (dout),
      .sop_o  (dout_sop),
      .eop_o  (dout_eop),
      .vld_o  (dout_vld),
      .cnt_o  (bufCnt)
   );

   assign fifo_rd_en = rdEn;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_ipml_prefetch_frame_reader.sv
// Self-checking bench: a sequence-numbered FIFO model feeds the reader while a frame-level
// reference model predicts every output word, handshake and counter each cycle.
module tb_ipml_prefetch_frame_reader;

   localparam int DW = 32;
   localparam int LW = 16;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] frame_len;
   logic          abort;
   logic          busy;
   logic          done;
   logic [SW-1:0] stall_cnt;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_rd_vld;
   logic          fifo_rd_en;
   logic [DW-1:0] dout;
   logic          dout_vld;
   logic          dout_sop;
   logic          dout_eop;
   logic          dout_rdy;

   // FIFO model: contents are the sequence numbers [nextRd, nextWr).
   int   nextRd = 0;
   int   nextWr = 0;
   logic gateVld;

   int checkCount = 0;
   int errorCount = 0;

   // Frame-level reference: words popped and delivered within the current frame.
   bit mActive;
   bit mDoneExp;
   int mLen, mBase, mPops, mOuts, mStall;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] wordOf(int seq);
      return 32'hC0DE_0000 + 32'(seq);
   endfunction

   assign fifo_rd_vld  = gateVld && (nextWr != nextRd);
   assign fifo_rd_data = wordOf(nextRd);

   ipml_prefetch_frame_reader #(
      .DATA_WIDTH(DW),
      .LEN_WIDTH(LW),
      .STALL_CNT_WIDTH(SW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .frame_len(frame_len),
      .abort(abort),
      .busy(busy),
      .done(done),
      .stall_cnt(stall_cnt),
      .fifo_rd_data(fifo_rd_data),
      .fifo_rd_vld(fifo_rd_vld),
      .fifo_rd_en(fifo_rd_en),
      .dout(dout),
      .dout_vld(dout_vld),
      .dout_sop(dout_sop),
      .dout_eop(dout_eop),
      .dout_rdy(dout_rdy)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Compares this cycle's outputs with the model, then advances the model past the clock edge.
   task automatic monitorCycle(output bit popNow);
      int buffered;
      bit expEn;
      bit outXfer;
      popNow = fifo_rd_vld && fifo_rd_en;
      if (rst) begin
         checkOutput("rd_en_in_reset", fifo_rd_en, 0);
         mActive  = 0;
         mDoneExp = 0;
         mStall   = 0;
         return;
      end
      buffered = mPops - mOuts;
      expEn = mActive && (mPops < mLen) && (buffered < 2) && fifo_rd_vld && !abort;
      checkOutput("rd_en", fifo_rd_en, expEn);
      checkOutput("busy", busy, mActive);
      checkOutput("done", done, mDoneExp);
      checkOutput("stall_cnt", stall_cnt, mStall);
      checkOutput("dout_vld", dout_vld, mActive && (buffered > 0));
      if (dout_vld && mActive && (buffered > 0)) begin
         checkOutput("dout", dout, wordOf(mBase + mOuts));
         checkOutput("dout_sop", dout_sop, mOuts == 0);
         checkOutput("dout_eop", dout_eop, mOuts == mLen - 1);
      end
      outXfer  = dout_vld && dout_rdy;
      mDoneExp = 0;
      if (mActive) begin
         if ((mPops < mLen) && (buffered < 2) && !fifo_rd_vld && (mStall < 65535)) mStall++;
         if (abort) begin
            mActive = 0;
         end else begin
            if (popNow) mPops++;
            if (outXfer) begin
               mOuts++;
               if (mOuts == mLen) begin
                  mActive  = 0;
                  mDoneExp = 1;
               end
            end
         end
      end else if (start && !abort) begin
         mStall = 0;
         mBase  = nextRd;
         if (frame_len == '0) begin
            mDoneExp = 1;
         end else begin
            mActive = 1;
            mLen    = int'(frame_len);
            mPops   = 0;
            mOuts   = 0;
         end
      end
   endtask

   task automatic tick();
      bit popNow;
      @(negedge clk);
      monitorCycle(popNow);
      @(posedge clk);
      #1;
      if (popNow) nextRd++;
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic applyStimulus(input bit doStart, input int len, input bit doAbort);
      start     = doStart;
      frame_len = LW'(len);
      abort     = doAbort;
      tick();
   endtask

   task automatic waitIdle(input string tag, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (!mActive && !busy) break;
         tick();
      end
      if (i == budget) checkOutput({"timeout_", tag}, 1, 0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_stall"}, stall_cnt, 0);
      checkOutput({tag, "_rd_en"}, fifo_rd_en, 0);
      checkOutput({tag, "_vld"}, dout_vld, 0);
      checkOutput({tag, "_dout"}, dout, 0);
      checkOutput({tag, "_sop"}, dout_sop, 0);
      checkOutput({tag, "_eop"}, dout_eop, 0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      frame_len = '0;
      dout_rdy  = 1'b1;
      gateVld   = 1'b1;
      mActive   = 0;
      mDoneExp  = 0;
      mStall    = 0;
      repeat (3) tick();
      rst = 1'b0;
      checkResetValues("reset");

      $display("[TB] test 1: frame of 4 from 8 words");
      nextWr = nextRd + 8;
      applyStimulus(1, 4, 0);
      waitIdle("t1", 50);
      tick();
      checkOutput("t1_fifo_left", nextWr - nextRd, 4);
      checkOutput("t1_stall", stall_cnt, 0);

      $display("[TB] test 2: backpressure mid-frame");
      nextRd = nextWr;
      nextWr = nextRd + 10;
      applyStimulus(1, 6, 0);
      repeat (2) tick();
      dout_rdy = 1'b0;
      repeat (5) tick();
      checkOutput("t2_rd_en_low", fifo_rd_en, 0);
      checkOutput("t2_vld_held", dout_vld, 1);
      dout_rdy = 1'b1;
      waitIdle("t2", 50);
      tick();
      checkOutput("t2_fifo_left", nextWr - nextRd, 4);

      $display("[TB] test 3: FIFO starvation");
      nextRd = nextWr;
      nextWr = nextRd + 10;
      applyStimulus(1, 5, 0);
      repeat (2) tick();
      gateVld = 1'b0;
      repeat (3) tick();
      gateVld = 1'b1;
      waitIdle("t3", 50);
      tick();
      checkOutput("t3_stall", stall_cnt, 3);

      $display("[TB] test 4: single-word and empty frames");
      applyStimulus(1, 1, 0);
      waitIdle("t4a", 20);
      tick();
      begin
         int rdBefore;
         rdBefore = nextRd;
         applyStimulus(1, 0, 0);
         checkOutput("t4_len0_done", done, 1);
         tick();
         checkOutput("t4_len0_no_read", nextRd - rdBefore, 0);
      end

      $display("[TB] test 5: abort after second pop");
      nextRd = nextWr;
      nextWr = nextRd + 8;
      applyStimulus(1, 8, 0);
      repeat (2) tick();
      applyStimulus(0, 0, 1);
      checkOutput("t5_busy", busy, 0);
      checkOutput("t5_vld", dout_vld, 0);
      checkOutput("t5_fifo_left", nextWr - nextRd, 6);
      applyStimulus(1, 2, 0);
      waitIdle("t5", 30);
      tick();
      checkOutput("t5_fifo_after", nextWr - nextRd, 4);

      $display("[TB] test 6: ignored starts and mid-frame reset");
      nextWr = nextRd + 12;
      applyStimulus(1, 6, 0);
      tick();
      applyStimulus(1, 3, 0);
      waitIdle("t6a", 50);
      tick();
      checkOutput("t6_fifo_left", nextWr - nextRd, 6);
      applyStimulus(1, 3, 1);
      checkOutput("t6_start_abort_busy", busy, 0);
      applyStimulus(1, 5, 0);
      repeat (2) tick();
      dout_rdy = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dout_rdy = 1'b1;
      checkResetValues("midrst");

      $display("[TB] random phase");
      for (int n = 0; n < 600; n++) begin
         if (nextWr - nextRd < 12) nextWr = nextWr + 8;
         gateVld  = ($urandom_range(0, 3) != 0);
         dout_rdy = ($urandom_range(0, 3) != 0);
         applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 9), $urandom_range(0, 40) == 0);
      end
      gateVld  = 1'b1;
      dout_rdy = 1'b1;
      waitIdle("random_end", 100);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
